// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, FSM state type and Q8.8 round/saturate helper for fc_output_mac.
// Revision: 1.0
`default_nettype none

package fc_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 40;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUT    = 2'd2
  } fc_mac_state_t;

  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN  = -SAT_MAX - (ACC_W+1)'(1);

  // One extra bit of headroom so the rounding constant can never wrap the sum.
  function automatic logic [DATA_W-1:0] sat_q88(input logic [ACC_W-1:0] acc);
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] r;
    t = {acc[ACC_W-1], acc};
    t = t + RND_HALF;
    r = t >>> FRAC_W;
    if (r > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return r[DATA_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_round_sat.sv
// fc_round_sat: one output lane -- bias add, round-half-up, shift to Q8.8, saturate, optional ReLU.
// Build option: FC_OUTPUT_RELU_EN clamps negative results to zero. Revision: 1.0
`default_nettype none

module fc_round_sat
  import fc_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] bias,
  output logic [DATA_W-1:0] result
);

  logic [ACC_W-1:0]  biased;
  logic [DATA_W-1:0] sat;

  always_comb begin
    biased = acc + ({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W);
    sat    = sat_q88(biased);
`ifdef FC_OUTPUT_RELU_EN
    result = sat[DATA_W-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

endmodule

`default_nettype wire

// File: rtl/fc_output_mac.sv
// fc_output_mac: streamed final FC layer MAC producing N_OUT registered Q8.8 scores with valid/ready.
// Build option: FC_OUTPUT_RELU_EN (see fc_round_sat). Revision: 1.0
`default_nettype none

module fc_output_mac
  import fc_pkg::*;
#(
  parameter int N_IN  = 64,
  parameter int N_OUT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic [N_OUT*DATA_W-1:0] w_data,
  input  logic [N_OUT*DATA_W-1:0] bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] values
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = 2 * DATA_W;

  fc_mac_state_t           state;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        acc      [N_OUT];
  logic signed [PROD_W-1:0] prod    [N_OUT];
  logic [N_OUT*DATA_W-1:0] lane_res;
  logic                    accept;

  assign accept = in_valid && in_ready && (state == ACCUM);

  always_comb begin
    for (int j = 0; j < N_OUT; j++)
      prod[j] = $signed(in_data) * $signed(w_data[j*DATA_W +: DATA_W]);
  end

  generate
    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
      fc_round_sat u_round_sat (
        .acc    (acc[j]),
        .bias   (bias[j*DATA_W +: DATA_W]),
        .result (lane_res[j*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // in_ready is a registered copy of "state is ACCUM" so it stays low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      values    <= '0;
      for (int j = 0; j < N_OUT; j++)
        acc[j] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            for (int j = 0; j < N_OUT; j++)
              acc[j] <= acc[j] + {{(ACC_W-PROD_W){prod[j][PROD_W-1]}}, prod[j]};
            cnt <= cnt + 1'b1;
            if (in_last || (cnt == CNT_W'(N_IN - 1))) begin
              state    <= FINISH;
              in_ready <= 1'b0;
            end
          end
        end
        FINISH: begin
          values    <= lane_res;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
            for (int j = 0; j < N_OUT; j++)
              acc[j] <= '0;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fc_output_mac.sv
// tb_fc_output_mac: directed self-checking bench for fc_output_mac with hand-computed Q8.8 results.
// Revision: 1.0
`default_nettype none

module tb_fc_output_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [31:0] w_data;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] values;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fc_output_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .w_data    (w_data),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .values    (values)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, in_ready}, 32'd1);
  endtask

  // Drive one beat at the current negedge; it is taken at the following posedge.
  task automatic beat(input logic [15:0] d, input logic [15:0] w0, input logic [15:0] w1,
                      input logic last);
    in_valid = 1'b1;
    in_data  = d;
    w_data   = {w1, w0};
    in_last  = last;
    @(negedge clk);
  endtask

  task automatic finish_frame(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_ov_t1"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_t1"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ov_t2"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_lane0"}, {16'd0, values[15:0]}, {16'd0, e0});
    check({tag, "_lane1"}, {16'd0, values[31:16]}, {16'd0, e1});
  endtask

  logic [15:0] exp_neg;
  logic [31:0] held;

  initial begin
`ifdef FC_OUTPUT_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'h8000;
`endif
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    w_data = '0; bias = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_values", values, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Basic values: 1*1+2*1 = 3.0 ; 1*0.5 + 2*(-1) = -1.5
    wait_ready("basic_ready");
    beat(16'h0100, 16'h0100, 16'h0080, 1'b0);
    beat(16'h0200, 16'h0100, 16'hFF00, 1'b1);
    finish_frame("basic", 16'h0300, 16'hFE80);

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds toward +inf to 0
    @(negedge clk);
    wait_ready("round_ready");
    beat(16'h0001, 16'h0080, 16'hFF80, 1'b1);
    finish_frame("round", 16'h0001, 16'h0000);

    // Saturation at the N_IN cap with no in_last
    @(negedge clk);
    wait_ready("sat_ready");
    for (int i = 0; i < 64; i++)
      beat(16'h7FFF, 16'h7FFF, 16'h8001, 1'b0);
    finish_frame("sat", 16'h7FFF, exp_neg);

    // Bias only
    @(negedge clk);
    wait_ready("bias_ready");
    bias = {16'hFF00, 16'h0180};
    beat(16'h0000, 16'h1234, 16'h4321, 1'b1);
`ifdef FC_OUTPUT_RELU_EN
    finish_frame("bias", 16'h0180, 16'h0000);
`else
    finish_frame("bias", 16'h0180, 16'hFF00);
`endif
    @(negedge clk);
    bias = '0;

    // Backpressure: result held, input not absorbed
    wait_ready("bp_ready");
    out_ready = 1'b0;
    beat(16'h0100, 16'h0100, 16'h0100, 1'b1);
    finish_frame("bp", 16'h0100, 16'h0100);
    held = values;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100;
      w_data   = {16'h0100, 16'h0100};
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_hold_values", values, held);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_ov", {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ov", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    beat(16'h0200, 16'h0100, 16'h0080, 1'b1);
    finish_frame("bp_next", 16'h0200, 16'h0100);

    // Reset mid-frame discards partial sums
    @(negedge clk);
    wait_ready("mid_ready");
    for (int i = 0; i < 3; i++)
      beat(16'h0100, 16'h0100, 16'h0100, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst_values", values, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wait_ready("after_rst_ready");
    beat(16'h0100, 16'h0100, 16'h0100, 1'b1);
    finish_frame("after_rst", 16'h0100, 16'h0100);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
